// File: rtl/sisc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sisc_pkg
// Brief   : Shared types and helpers for the SISC memory arbiter.
//           Holds the arbiter state encoding, the port-select encoding and
//           a counter-width helper.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
package sisc_pkg;

  // Arbiter sequencing states (2-bit encoding).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Which requester owns the current access.
  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_D  = 1'b1
  } sel_t;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sisc_mem_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sisc_mem_arb_if
// Brief   : Requester and memory-side signal bundle of the SISC memory
//           arbiter. slave = arbiter view, master = requesters + memory.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
interface sisc_mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  // Instruction-fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  // Data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  // Memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Status
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/sisc_arb_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sisc_arb_sel
// Brief   : Combinational winner selection. Data has fixed priority unless
//           fetch has been passed over STARVE_MAX times in a row.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module sisc_arb_sel
  import sisc_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] starve_cnt,
  output logic          win_valid,
  output sel_t          win_sel
);

  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  // Pick data unless both request and fetch has reached its starvation limit.
  always_comb begin
    win_valid = if_req | d_req;
    win_sel   = SEL_IF;
    if (d_req && !(if_req && (starve_cnt == STARVE_TOP))) begin
      win_sel = SEL_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sisc_mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sisc_mem_arb
// Brief   : Single-port memory arbiter between instruction fetch and data
//           (LOD/STR). Sequences each access over MEM_LAT cycles, then
//           returns a one-cycle rvalid pulse to the winning port.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module sisc_mem_arb
  import sisc_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_f,
  sisc_mem_arb_if.slave  bus
);

  localparam int LW = cnt_w(MEM_LAT);
  localparam int SW = cnt_w(STARVE_MAX);
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  sel_t          sel;
  sel_t          win_sel;
  logic          win_valid;
  logic          grant;
  logic          last_cyc;
  logic [AW-1:0] addr_lat;
  logic [DW-1:0] wdata_lat;

  sisc_arb_sel #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_sel (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .starve_cnt (starve_cnt),
    .win_valid  (win_valid),
    .win_sel    (win_sel)
  );

  assign bus.mem_addr  = addr_lat;
  assign bus.mem_wdata = wdata_lat;
  assign bus.busy      = (state != IDLE);

  // Next-state logic plus the grant / final-access-cycle strobes.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    last_cyc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_cnt == LAT_LAST) begin
          last_cyc  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nxt;
  end

  // Access sequencing: latch request on grant, hold memory strobes, return data.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      sel           <= SEL_IF;
      lat_cnt       <= '0;
      addr_lat      <= '0;
      wdata_lat     <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_gnt    <= grant && (win_sel == SEL_IF);
      bus.d_gnt     <= grant && (win_sel == SEL_D);
      bus.if_rvalid <= last_cyc && (sel == SEL_IF);
      bus.d_rvalid  <= last_cyc && (sel == SEL_D);
      bus.mem_en    <= (state_nxt == ACCESS);

      if (grant) begin
        sel     <= win_sel;
        lat_cnt <= '0;
        if (win_sel == SEL_D) begin
          bus.mem_we <= bus.d_we;
          addr_lat   <= bus.d_addr;
          wdata_lat  <= bus.d_wdata;
        end else begin
          bus.mem_we <= 1'b0;
          addr_lat   <= bus.if_addr;
          wdata_lat  <= '0;
        end
      end else if (state == ACCESS) begin
        lat_cnt <= lat_cnt + LW'(1);
        // Write enable drops together with mem_en at the end of the access.
        if (last_cyc) bus.mem_we <= 1'b0;
      end

      if (last_cyc) begin
        if (sel == SEL_D) bus.d_rdata  <= bus.mem_we ? '0 : bus.mem_rdata;
        else              bus.if_rdata <= bus.mem_rdata;
      end
    end
  end

  // Count data grants that pass over a waiting fetch; fetch wins at the limit.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!bus.if_req) begin
        starve_cnt <= '0;
      end else if (grant && (win_sel == SEL_IF)) begin
        starve_cnt <= '0;
      end else if (grant && (starve_cnt != STARVE_TOP)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sisc_mem_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_sisc_mem_arb
// Brief   : Self-checking bench for sisc_mem_arb (MEM_LAT=2, STARVE_MAX=2).
//           A schedule model predicts every output per cycle; directed
//           scenarios add hand-computed literal expectations.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_sisc_mem_arb;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 2;
  localparam int N = 1024;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  sisc_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  sisc_mem_arb #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [31:0] init_val(input int a);
    case (a)
      8'h40:   return 32'hDEADBEEF;
      0:       return 32'hA0A00000;
      1:       return 32'hA1A10001;
      default: return 32'h5A000000 | 32'(a);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Memory model attached to the DUT
  logic [31:0] mem [0:255];
  bit mem_loaded = 1'b0;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  // Expected per-cycle outputs
  bit          e_if_gnt [N];
  bit          e_d_gnt  [N];
  bit          e_if_rv  [N];
  bit          e_d_rv   [N];
  bit          e_en     [N];
  bit          e_we     [N];
  bit          e_busy   [N];
  logic [31:0] e_rdata  [N];
  logic [15:0] e_addr   [N];
  logic [31:0] e_wdata  [N];

  logic [31:0] ref_mem [256];
  bit ref_loaded = 1'b0;
  int next_free = 0;
  int starve = 0;

  // Schedule model: an access won at edge e owns the memory for cycles
  // e+1..e+MEM_LAT+1, and the next arbitration is at edge e+MEM_LAT+2.
  always @(posedge clk or negedge rst_f) begin
    int e;
    bit take_d, take_if;
    logic [31:0] rd;
    if (!ref_loaded) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_loaded = 1'b1;
    end
    if (!rst_f) begin
      if (clk) cyc++;
      for (int i = cyc; i < N; i++) begin
        e_if_gnt[i] = 0; e_d_gnt[i] = 0; e_if_rv[i] = 0; e_d_rv[i] = 0;
        e_en[i] = 0; e_we[i] = 0; e_busy[i] = 0;
      end
      next_free = cyc;
      starve = 0;
    end else begin
      e = cyc;
      if (e >= next_free && e + MEM_LAT + 2 < N) begin
        take_d  = bus.d_req && (!bus.if_req || starve < STARVE_MAX);
        take_if = bus.if_req && !take_d;
        if (!bus.if_req) starve = 0;
        if (take_d && bus.if_req) starve = starve + 1;
        if (take_if) starve = 0;
        if (take_d || take_if) begin
          if (take_d && bus.d_we) begin
            ref_mem[bus.d_addr[7:0]] = bus.d_wdata;
            rd = 32'h0;
          end else begin
            rd = ref_mem[take_d ? bus.d_addr[7:0] : bus.if_addr[7:0]];
          end
          if (take_d) e_d_gnt[e+1] = 1; else e_if_gnt[e+1] = 1;
          for (int k = 1; k <= MEM_LAT; k++) begin
            e_en[e+k]    = 1;
            e_we[e+k]    = take_d && bus.d_we;
            e_addr[e+k]  = take_d ? bus.d_addr : bus.if_addr;
            e_wdata[e+k] = bus.d_wdata;
          end
          for (int k = 1; k <= MEM_LAT + 1; k++) e_busy[e+k] = 1;
          if (take_d) e_d_rv[e+MEM_LAT+1] = 1; else e_if_rv[e+MEM_LAT+1] = 1;
          e_rdata[e+MEM_LAT+1] = rd;
          next_free = e + MEM_LAT + 2;
        end
      end
      cyc++;
    end
  end

  // Per-cycle comparison of every DUT output against the model
  logic [31:0] h_if = '0;
  logic [31:0] h_d = '0;
  always @(negedge clk) begin
    if (cyc < N) begin
      if (!rst_f) begin
        h_if = '0;
        h_d  = '0;
        chk("mem_addr_rst", 64'(bus.mem_addr), 64'h0);
        chk("mem_wdata_rst", 64'(bus.mem_wdata), 64'h0);
      end else begin
        if (e_if_rv[cyc]) h_if = e_rdata[cyc];
        if (e_d_rv[cyc])  h_d  = e_rdata[cyc];
      end
      chk("if_gnt", 64'(bus.if_gnt), 64'(e_if_gnt[cyc]));
      chk("d_gnt", 64'(bus.d_gnt), 64'(e_d_gnt[cyc]));
      chk("if_rvalid", 64'(bus.if_rvalid), 64'(e_if_rv[cyc]));
      chk("d_rvalid", 64'(bus.d_rvalid), 64'(e_d_rv[cyc]));
      chk("if_rdata", 64'(bus.if_rdata), 64'(h_if));
      chk("d_rdata", 64'(bus.d_rdata), 64'(h_d));
      chk("mem_en", 64'(bus.mem_en), 64'(e_en[cyc]));
      chk("mem_we", 64'(bus.mem_we), 64'(e_we[cyc]));
      chk("busy", 64'(bus.busy), 64'(e_busy[cyc]));
      if (e_en[cyc] && rst_f) begin
        chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr[cyc]));
        if (e_we[cyc]) chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata[cyc]));
      end
    end
  end

  function automatic logic sig_val(input int code);
    case (code)
      0:       return bus.if_gnt;
      1:       return bus.d_gnt;
      2:       return bus.if_rvalid;
      default: return bus.d_rvalid;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int code, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sig_val(code)) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s timeout actual=none expected=pulse", name);
  endtask

  task automatic wait_any_gnt(output int at, output bit is_d);
    at = -1;
    is_d = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.if_gnt || bus.d_gnt) begin
        at = cyc;
        is_d = bus.d_gnt;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL any_gnt timeout actual=none expected=pulse");
  endtask

  initial begin
    int rc, t, t2, cnt_rv, cnt_gnt, cnt_en, cnt_busy;
    int gt [6];
    bit gd [6];
    bit exp_order [6];
    exp_order[0] = 1; exp_order[1] = 1; exp_order[2] = 0;
    exp_order[3] = 1; exp_order[4] = 1; exp_order[5] = 0;

    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    rst_f = 1;
    @(negedge clk);

    // Reset during the ACCESS phase of a store
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0010; bus.d_wdata = 32'hCAFEF00D;
    wait_sig("rst_store_gnt", 1, t);
    bus.d_req = 0; bus.d_we = 0;
    @(negedge clk);
    #2 rst_f = 0;
    #1;
    chk("rst_mem_en", 64'(bus.mem_en), 64'h0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_d_rvalid", 64'(bus.d_rvalid), 64'h0);
    repeat (2) @(negedge clk);
    rst_f = 1;
    cnt_rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.d_rvalid) cnt_rv++;
    end
    chk("rst_no_rvalid", 64'(cnt_rv), 64'h0);
    chk("rst_busy_after", 64'(bus.busy), 64'h0);

    // Single load
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0040;
    rc = cyc;
    wait_sig("load_gnt", 1, t);
    chk("load_gnt_lat", 64'(t - rc), 64'd1);
    chk("load_mem_addr", 64'(bus.mem_addr), 64'h0040);
    bus.d_req = 0;
    wait_sig("load_rv", 3, t2);
    chk("load_rv_lat", 64'(t2 - rc), 64'd3);
    chk("load_rdata", 64'(bus.d_rdata), 64'hDEADBEEF);

    // Store
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0005; bus.d_wdata = 32'h12345678;
    wait_sig("store_gnt", 1, t);
    chk("store_mem_we", 64'(bus.mem_we), 64'h1);
    bus.d_req = 0; bus.d_we = 0; bus.d_wdata = 32'hFFFF0000;
    wait_sig("store_rv", 3, t2);
    chk("store_rdata", 64'(bus.d_rdata), 64'h0);
    @(negedge clk);
    chk("store_mem5", 64'(mem[5]), 64'h12345678);

    // Fetch only, request held after grant with a new address
    bus.if_req = 1; bus.if_addr = 16'h0000;
    wait_sig("fetch_gnt0", 0, t);
    bus.if_addr = 16'h0001;
    wait_sig("fetch_rv0", 2, t2);
    chk("fetch_rv_lat", 64'(t2 - t), 64'd2);
    chk("fetch_rdata0", 64'(bus.if_rdata), 64'hA0A00000);
    wait_sig("fetch_gnt1", 0, t2);
    chk("fetch_gnt_spacing", 64'(t2 - t), 64'd4);
    bus.if_req = 0;
    wait_sig("fetch_rv1", 2, t);
    chk("fetch_rdata1", 64'(bus.if_rdata), 64'hA1A10001);

    // Both requesters held: fetch forced in after STARVE_MAX data grants
    repeat (2) @(negedge clk);
    bus.if_req = 1; bus.if_addr = 16'h0000;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0040;
    for (int i = 0; i < 6; i++) wait_any_gnt(gt[i], gd[i]);
    bus.if_req = 0; bus.d_req = 0;
    for (int i = 0; i < 6; i++) chk($sformatf("order_%0d", i), 64'(gd[i]), 64'(exp_order[i]));
    for (int i = 1; i < 6; i++) chk($sformatf("spacing_%0d", i), 64'(gt[i] - gt[i-1]), 64'd4);

    // Request withdrawn before the sampling edge
    repeat (5) @(negedge clk);
    bus.d_req = 1; bus.d_addr = 16'h0040;
    #3 bus.d_req = 0;
    cnt_gnt = 0; cnt_en = 0; cnt_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.d_gnt) cnt_gnt++;
      if (bus.mem_en) cnt_en++;
      if (bus.busy) cnt_busy++;
    end
    chk("withdraw_gnt", 64'(cnt_gnt), 64'h0);
    chk("withdraw_mem_en", 64'(cnt_en), 64'h0);
    chk("withdraw_busy", 64'(cnt_busy), 64'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
